// File: rtl/demux_rr_sequencer_if.sv
// Stream-in / per-channel-out handshake bundle between the sequencer and its 1:8 demux.
// The master side is the sequencer; the slave side is the source plus channel sinks.
interface demux_rr_sequencer_if #(
  parameter int DATA_W = 8
) ();
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [7:0]        m_valid;
  logic [DATA_W-1:0] m_data;
  logic [7:0]        m_ready;
  logic [2:0]        sel;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, sel
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, sel
  );
endinterface

// File: rtl/demux_rr_sequencer.sv
// Round-robin burst scheduler feeding a 1:8 demux; zero-latency data passthrough while bursting.
// Backpressure: s_ready mirrors the owning channel's ready, stalls hold the burst indefinitely.
module demux_rr_sequencer #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            en_mask,
  demux_rr_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  burst_done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_XFER  = 1'b1;
  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  logic [0:0] state;
  logic [2:0] ptr;
  logic [2:0] sel_q;
  logic [7:0] cnt;
  logic [2:0] pick_base;
  logic       pick_ok;
  logic [2:0] pick_idx;
  logic       beat;

  // First enabled channel at or after base, wrapping mod 8.
  function automatic logic [3:0] pick_from(input logic [2:0] base, input logic [7:0] mask);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = base + 3'(k);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // In XFER the only pick that matters is the one taken at the last beat, from sel+1.
  always_comb begin
    pick_base           = (state == ST_XFER) ? sel_q + 3'd1 : ptr;
    {pick_ok, pick_idx} = pick_from(pick_base, en_mask);
  end

  always_comb begin
    bus.s_ready = 1'b0;
    bus.m_valid = 8'd0;
    bus.m_data  = '0;
    if (state == ST_XFER) begin
      bus.s_ready = bus.m_ready[sel_q];
      bus.m_valid = 8'(bus.s_valid) << sel_q;
      bus.m_data  = bus.s_data;
    end
  end

  assign beat    = (state == ST_XFER) && bus.s_valid && bus.m_ready[sel_q];
  assign busy    = (state == ST_XFER);
  assign bus.sel = sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= 3'd0;
      sel_q      <= 3'd0;
      cnt        <= 8'd0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (pick_ok) begin
          sel_q <= pick_idx;
          cnt   <= 8'd0;
          state <= ST_XFER;
        end
      end else if (beat) begin
        if (cnt == LAST_CNT) begin
          // Re-pick in the same edge so consecutive bursts have no bubble.
          ptr        <= sel_q + 3'd1;
          burst_done <= 1'b1;
          cnt        <= 8'd0;
          if (pick_ok) sel_q <= pick_idx;
          else         state <= ST_IDLE;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_sequencer.sv
// Self-checking bench: randomized and directed stimulus against a burst-level reference model.
module tb_demux_rr_sequencer;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] en_mask;
  logic       busy;
  logic       burst_done;

  logic       rst1;
  logic [7:0] en1;
  logic       busy1;
  logic       done1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner channel, beats still owed in the burst, next start point.
  bit mb_busy;
  int mb_owner;
  int mb_left;
  int mb_next;
  bit mb_pulse;

  demux_rr_sequencer_if #(.DATA_W(8)) bus ();
  demux_rr_sequencer_if #(.DATA_W(8)) bus1 ();

  demux_rr_sequencer #(.DATA_W(8), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .en_mask(en_mask), .bus(bus),
    .busy(busy), .burst_done(burst_done)
  );

  demux_rr_sequencer #(.DATA_W(8), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst1), .en_mask(en1), .bus(bus1),
    .busy(busy1), .burst_done(done1)
  );

  always #5 clk = ~clk;

  function automatic int first_enabled(int start, logic [7:0] mask);
    for (int k = 0; k < 8; k++)
      if (mask[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    mb_busy = 0; mb_owner = 0; mb_left = 0; mb_next = 0; mb_pulse = 0;
  endtask

  task automatic model_edge();
    int f;
    if (rst) begin
      model_reset();
      return;
    end
    mb_pulse = 0;
    if (!mb_busy) begin
      f = first_enabled(mb_next, en_mask);
      if (f >= 0) begin
        mb_busy = 1; mb_owner = f; mb_left = BL;
      end
    end else if (bus.s_valid && bus.m_ready[mb_owner]) begin
      mb_left--;
      if (mb_left == 0) begin
        mb_next  = (mb_owner + 1) % 8;
        mb_pulse = 1;
        f = first_enabled(mb_next, en_mask);
        if (f >= 0) begin
          mb_owner = f; mb_left = BL;
        end else begin
          mb_busy = 0;
        end
      end
    end
  endtask

  function automatic logic [21:0] exp_vec();
    logic [7:0] v, d;
    logic       r;
    v = 8'd0; d = 8'd0; r = 1'b0;
    if (mb_busy) begin
      d = bus.s_data;
      r = bus.m_ready[mb_owner];
      if (bus.s_valid) v = 8'd1 << mb_owner;
    end
    return {v, r, 3'(mb_owner), logic'(mb_busy), logic'(mb_pulse), d};
  endfunction

  function automatic logic [21:0] obs_vec();
    return {bus.m_valid, bus.s_ready, bus.sel, busy, burst_done, bus.m_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input logic [7:0] mask);
    rst = 1'b1;
    model_reset();
    en_mask = mask;
    bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.m_ready = 8'd0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b1; bus.m_ready = 8'hFF; bus.s_data = 8'h5A; en_mask = 8'hFF;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({bus.m_valid, bus.s_ready, bus.sel, busy, burst_done, bus.m_data} !== 22'd0)
      $display("FAIL reset_outputs got %h want 0", obs_vec());
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_held got %h want %h", obs_vec(), exp_vec());
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({busy, bus.sel} !== 4'b1_000) $display("FAIL reset_release busy/sel got %b want 1000", {busy, bus.sel});
    else n_pass++;
  endtask

  task automatic test_full_rotation();
    logic [8:0] want;
    do_reset(8'hFF);
    bus.s_valid = 1'b1; bus.m_ready = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      bus.s_data = 8'(c);
      #1;
      want = {8'(8'd1 << ((c / 4) % 8)), logic'(c > 0 && c % 4 == 0)};
      n_checks++;
      if ({bus.m_valid, burst_done} !== want)
        $display("FAIL rotation beat %0d m_valid/done got %h want %h", c, {bus.m_valid, burst_done}, want);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL rotation_model cyc %0d got %h want %h", c, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_skip_mask();
    int q[$];
    int exp_seq[4] = '{2, 5, 7, 2};
    int got;
    do_reset(8'b1010_0100);
    bus.s_valid = 1'b1; bus.m_ready = 8'hFF;
    for (int c = 0; c < 13; c++) begin
      bus.s_data = 8'(c + 100);
      #1;
      if (c == 0 || burst_done) q.push_back(int'(bus.sel));
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL skip_model cyc %0d got %h want %h", c, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : -1;
      n_checks++;
      if (got !== exp_seq[i]) $display("FAIL skip_seq[%0d] got %0d want %0d", i, got, exp_seq[i]);
      else n_pass++;
    end
    do_reset(8'h00);
    bus.s_valid = 1'b1; bus.m_ready = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++;
      if ({busy, bus.s_ready, bus.m_valid} !== 10'd0)
        $display("FAIL empty_mask cyc %0d busy/s_ready/m_valid got %h want 0", c, {busy, bus.s_ready, bus.m_valid});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int  ch3_beats = 0;
    bit  seen_done = 0;
    bit  m4_during = 0;
    do_reset(8'h18);
    bus.s_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus.m_ready = (c >= 2 && c < 7) ? 8'h10 : 8'hFF;
      bus.s_data  = 8'(c + 200);
      #1;
      if (burst_done) seen_done = 1;
      if (!seen_done) begin
        if (bus.m_valid[3] && bus.s_ready) ch3_beats++;
        if (bus.m_valid[4]) m4_during = 1;
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL backpressure_model cyc %0d got %h want %h", c, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (ch3_beats !== 4) $display("FAIL backpressure_beats got %0d want 4", ch3_beats);
    else n_pass++;
    n_checks++;
    if (m4_during !== 1'b0) $display("FAIL backpressure_m4 got %0d want 0", m4_during);
    else n_pass++;
  endtask

  task automatic test_mask_change();
    int  ch2_beats = 0;
    bit  back_to_2 = 0;
    do_reset(8'h05);
    bus.s_valid = 1'b1; bus.m_ready = 8'hFF;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) en_mask = 8'h01;
      bus.s_data = 8'(c + 50);
      #1;
      if (bus.m_valid[2] && bus.s_ready) ch2_beats++;
      if (c >= 8 && bus.sel == 3'd2) back_to_2 = 1;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL maskchg_model cyc %0d got %h want %h", c, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (ch2_beats !== 4) $display("FAIL maskchg_beats got %0d want 4", ch2_beats);
    else n_pass++;
    n_checks++;
    if (back_to_2 !== 1'b0) $display("FAIL maskchg_skip got %0d want 0", back_to_2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset(8'hFF);
    bus.s_valid = 1'b1; bus.m_ready = 8'hFF;
    for (int c = 0; c < 22; c++) begin
      bus.s_data = 8'(c);
      tick();
    end
    #1;
    n_checks++;
    if ({bus.sel, busy} !== 4'b101_1) $display("FAIL midreset_pre sel/busy got %b want 1011", {bus.sel, busy});
    else n_pass++;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== 22'd0) $display("FAIL midreset_outputs got %h want 0", obs_vec());
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({busy, bus.sel, bus.m_valid} !== {1'b1, 3'd0, 8'h01})
      $display("FAIL midreset_restart busy/sel/m_valid got %h want %h", {busy, bus.sel, bus.m_valid}, {1'b1, 3'd0, 8'h01});
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset(8'($urandom));
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) en_mask = 8'($urandom);
      bus.s_valid = ($urandom_range(0, 9) < 7);
      bus.m_ready = 8'($urandom);
      bus.s_data  = 8'($urandom);
      #1;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL random_model cyc %0d got %h want %h", c, obs_vec(), exp_vec());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_burst_len1();
    logic [2:0] want_sel;
    rst = 1'b1;
    model_reset();
    en1 = 8'h81; bus1.s_valid = 1'b1; bus1.m_ready = 8'hFF; bus1.s_data = 8'h33;
    rst1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      want_sel = (k % 2 == 1) ? 3'd7 : 3'd0;
      n_checks++;
      if ({busy1, bus1.sel, done1} !== {1'b1, want_sel, logic'(k > 0)})
        $display("FAIL bl1 step %0d busy/sel/done got %b want %b", k, {busy1, bus1.sel, done1},
                 {1'b1, want_sel, logic'(k > 0)});
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    en_mask = 8'h00; en1 = 8'h00;
    bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.m_ready = 8'd0;
    bus1.s_valid = 1'b0; bus1.s_data = 8'd0; bus1.m_ready = 8'd0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_full_rotation();
    test_skip_mask();
    test_backpressure();
    test_mask_change();
    test_reset_mid_burst();
    test_random();
    test_burst_len1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
